// File: rtl/press_counter_pkg.sv
// Shared widths and defaults for the push-button press counter.
package press_counter_pkg;

    localparam int COUNT_WIDTH            = 8;
    localparam int DEFAULT_DEBOUNCE_LIMIT = 50000;

endpackage

// File: rtl/press_counter_debouncer.sv
// Two-flop synchronizer followed by a hold-time debouncer; exposes the synchronized
// level and a one-cycle flag marking the edge where the debounced level will rise.
module debouncer
    import press_counter_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_key,
    output logic o_key_sync,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_count;
    logic             w_differs;
    logic             w_expired;

    assign w_differs = (r_sync2 != r_level);
    assign w_expired = w_differs && (r_count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            // Any cycle of agreement restarts the hold window
            if (!w_differs) begin
                r_count <= '0;
            end else if (w_expired) begin
                r_level <= r_sync2;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_key_sync = r_sync2;
    assign o_level    = r_level;
    assign o_rise     = w_expired && r_sync2;

endmodule

// File: rtl/press_counter.sv
// Counts raw and debounced presses of a bouncing push-button; the two 8-bit counts
// are packed side by side for a 4-digit hex display.
module press_counter
    import press_counter_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key,
    input  logic        clear,
    output logic [15:0] number,
    output logic        key_debounced
);

    logic                   w_key_sync;
    logic                   w_level;
    logic                   w_deb_rise;
    logic                   w_raw_rise;
    logic                   r_key_prev;
    logic [COUNT_WIDTH-1:0] r_raw_count;
    logic [COUNT_WIDTH-1:0] r_deb_count;

    debouncer #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debouncer (
        .clock     (clock),
        .reset     (reset),
        .i_key     (key),
        .o_key_sync(w_key_sync),
        .o_level   (w_level),
        .o_rise    (w_deb_rise)
    );

    assign w_raw_rise = w_key_sync && !r_key_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_key_prev  <= 1'b0;
            r_raw_count <= '0;
            r_deb_count <= '0;
        end else begin
            r_key_prev <= w_key_sync;
            // Clear wins over a coincident increment
            if (clear) begin
                r_raw_count <= '0;
                r_deb_count <= '0;
            end else begin
                if (w_raw_rise) r_raw_count <= r_raw_count + 1'b1;
                if (w_deb_rise) r_deb_count <= r_deb_count + 1'b1;
            end
        end
    end

    assign number        = {r_raw_count, r_deb_count};
    assign key_debounced = w_level;

endmodule

// File: tb/tb_press_counter.sv
// Directed self-checking bench for press_counter with a short debounce window.
module tb_press_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic        key;
    logic        clear;
    logic [15:0] number;
    logic        key_debounced;

    int checks   = 0;
    int errors   = 0;
    int rise_cnt = 0;

    press_counter #(
        .DEBOUNCE_LIMIT(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key          (key),
        .clear        (clear),
        .number       (number),
        .key_debounced(key_debounced)
    );

    always #5 clock = ~clock;

    always @(posedge key_debounced) rise_cnt++;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic press;
        key = 1'b1;
        repeat (8) tick();
        key = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        key   = 1'b0;
        clear = 1'b0;
        #1;
        repeat (3) tick();
        checks++;
        if (number !== 16'h0000) begin
            errors++;
            $display("FAIL reset_number: got %h expected %h", number, 16'h0000);
        end
        checks++;
        if (key_debounced !== 1'b0) begin
            errors++;
            $display("FAIL reset_kd: got %b expected %b", key_debounced, 1'b0);
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (number !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_idle: got %h expected %h", number, 16'h0000);
        end
        $display("test_reset done number=%h kd=%b", number, key_debounced);
    endtask

    task automatic test_single_press;
        key = 1'b1;
        tick();                 // edge N
        tick();                 // edge N+1
        checks++;
        if (number !== 16'h0000) begin
            errors++;
            $display("FAIL press_n1: got %h expected %h", number, 16'h0000);
        end
        tick();                 // edge N+2
        checks++;
        if (number !== 16'h0100) begin
            errors++;
            $display("FAIL press_raw_n2: got %h expected %h", number, 16'h0100);
        end
        tick();
        tick();                 // edge N+4
        checks++;
        if (number !== 16'h0100 || key_debounced !== 1'b0) begin
            errors++;
            $display("FAIL press_n4: got %h/%b expected %h/%b", number, key_debounced, 16'h0100, 1'b0);
        end
        tick();                 // edge N+5
        checks++;
        if (number !== 16'h0101 || key_debounced !== 1'b1) begin
            errors++;
            $display("FAIL press_deb_n5: got %h/%b expected %h/%b", number, key_debounced, 16'h0101, 1'b1);
        end
        repeat (14) tick();
        key = 1'b0;
        repeat (20) tick();
        checks++;
        if (number !== 16'h0101 || key_debounced !== 1'b0) begin
            errors++;
            $display("FAIL press_final: got %h/%b expected %h/%b", number, key_debounced, 16'h0101, 1'b0);
        end
        $display("test_single_press done number=%h", number);
    endtask

    task automatic test_glitches;
        int r0;
        do_clear();
        checks++;
        if (number !== 16'h0000) begin
            errors++;
            $display("FAIL clear_before_glitch: got %h expected %h", number, 16'h0000);
        end
        r0 = rise_cnt;
        key = 1'b1; tick();
        key = 1'b0; tick();
        key = 1'b1; tick();
        key = 1'b0; tick();
        key = 1'b1; tick();
        repeat (10) tick();
        key = 1'b0;
        repeat (10) tick();
        checks++;
        if (number !== 16'h0301) begin
            errors++;
            $display("FAIL glitch_number: got %h expected %h", number, 16'h0301);
        end
        checks++;
        if (rise_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL glitch_kd_rises: got %0d expected %0d", rise_cnt - r0, 1);
        end
        $display("test_glitches done number=%h rises=%0d", number, rise_cnt - r0);
    endtask

    task automatic test_wrap;
        do_clear();
        repeat (255) press();
        checks++;
        if (number !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_255: got %h expected %h", number, 16'hFFFF);
        end
        press();
        checks++;
        if (number !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_256: got %h expected %h", number, 16'h0000);
        end
        $display("test_wrap done number=%h", number);
    endtask

    task automatic test_clear_on_edge;
        do_clear();
        press();
        press();
        checks++;
        if (number !== 16'h0202) begin
            errors++;
            $display("FAIL clear_setup: got %h expected %h", number, 16'h0202);
        end
        // Two-cycle pulse: raw edge lands on the clear edge, too short to debounce
        key = 1'b1;
        tick();
        tick();
        clear = 1'b1;
        key   = 1'b0;
        tick();
        clear = 1'b0;
        checks++;
        if (number !== 16'h0000) begin
            errors++;
            $display("FAIL clear_on_edge: got %h expected %h", number, 16'h0000);
        end
        repeat (10) tick();
        checks++;
        if (number !== 16'h0000 || key_debounced !== 1'b0) begin
            errors++;
            $display("FAIL clear_settle: got %h/%b expected %h/%b", number, key_debounced, 16'h0000, 1'b0);
        end
        press();
        checks++;
        if (number !== 16'h0101) begin
            errors++;
            $display("FAIL clear_next_press: got %h expected %h", number, 16'h0101);
        end
        $display("test_clear_on_edge done number=%h", number);
    endtask

    task automatic test_reset_key_high;
        bit seen;
        do_clear();
        repeat (5) press();
        checks++;
        if (number !== 16'h0505) begin
            errors++;
            $display("FAIL rkh_setup: got %h expected %h", number, 16'h0505);
        end
        key = 1'b1;
        repeat (8) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (number !== 16'h0000 || key_debounced !== 1'b0) begin
            errors++;
            $display("FAIL rkh_async: got %h/%b expected %h/%b", number, key_debounced, 16'h0000, 1'b0);
        end
        tick();
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (number === 16'h0101) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rkh_timeout: got %h expected %h within 6 cycles", number, 16'h0101);
        end
        repeat (4) tick();
        checks++;
        if (number !== 16'h0101 || key_debounced !== 1'b1) begin
            errors++;
            $display("FAIL rkh_hold: got %h/%b expected %h/%b", number, key_debounced, 16'h0101, 1'b1);
        end
        key = 1'b0;
        repeat (10) tick();
        $display("test_reset_key_high done number=%h", number);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitches();
        test_wrap();
        test_clear_on_edge();
        test_reset_key_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
